// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: tracks destinations in flight, stalls on RAW hazards,
// honours memory freezes and branch flushes, and counts stall/freeze cycles.
module hazard_ctrl #(
   parameter int REG_W  = 3,
   parameter int FWD_EN = 0,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_rs_vld,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rt_vld,
   input  logic [REG_W-1:0] id_wr_reg,
   input  logic             id_wr_en,
   input  logic             id_is_load,
   input  logic             mem_busy,
   input  logic             flush,
   output logic             stall_id,
   output logic             bubble_ex,
   output logic             freeze,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] frz_cnt
);

   typedef enum logic [1:0] {
      ST_RUN = 2'b00,
      ST_HAZ = 2'b01,
      ST_FRZ = 2'b10
   } state_t;

   state_t cur_st, nxt_st;

   // Shadow of EX (index 0) and MEM (index 1) destinations. The WB entry can
   // never cause a hazard thanks to regfile write-bypass, so it is not stored.
   logic [1:0]       sh_vld;
   logic [REG_W-1:0] sh_reg [2];
   logic             sh_load;

   logic [1:0] match;
   logic       hazard;
   logic       haz_case;

   assign match[0] = sh_vld[0] & ((id_rs_vld & (sh_reg[0] == id_rs)) |
                                  (id_rt_vld & (sh_reg[0] == id_rt)));
   assign match[1] = sh_vld[1] & ((id_rs_vld & (sh_reg[1] == id_rs)) |
                                  (id_rt_vld & (sh_reg[1] == id_rt)));

   assign hazard = (FWD_EN != 0) ? (match[0] & sh_load) : (|match);

   // Priority: memory freeze, then flush, then RAW interlock.
   always_comb begin
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
      haz_case  = 1'b0;
      nxt_st    = ST_RUN;
      if (mem_busy) begin
         freeze   = 1'b1;
         stall_id = 1'b1;
         nxt_st   = ST_FRZ;
      end else if (flush) begin
         bubble_ex = 1'b1;
      end else if (id_valid && hazard) begin
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
         haz_case  = 1'b1;
         nxt_st    = ST_HAZ;
      end
   end

   assign state = cur_st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_st    <= ST_RUN;
         sh_vld    <= '0;
         sh_reg[0] <= '0;
         sh_reg[1] <= '0;
         sh_load   <= 1'b0;
         stall_cnt <= '0;
         frz_cnt   <= '0;
      end else begin
         cur_st <= nxt_st;
         if (!freeze) begin
            sh_vld[1] <= sh_vld[0];
            sh_reg[1] <= sh_reg[0];
            sh_vld[0] <= id_valid & id_wr_en & ~bubble_ex;
            sh_reg[0] <= id_wr_reg;
            sh_load   <= id_is_load;
         end
         if (haz_case && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (freeze && (frz_cnt != '1))
            frz_cnt <= frz_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dut 0 is the full interlock build, dut 1 the
// forwarding build with 2-bit counters so saturation is reachable.
module tb_hazard_ctrl;

   localparam int RUN = 0;
   localparam int HAZ = 1;
   localparam int FRZ = 2;

   logic       clk;
   logic       rst;
   logic [1:0] id_valid, id_rs_vld, id_rt_vld, id_wr_en, id_is_load, mem_busy, flush;
   logic [2:0] id_rs [2];
   logic [2:0] id_rt [2];
   logic [2:0] id_wr_reg [2];
   logic [1:0] stall_id, bubble_ex, freeze;
   logic [1:0] state [2];
   logic [15:0] stall_cnt_a, frz_cnt_a;
   logic [1:0]  stall_cnt_b, frz_cnt_b;

   logic [37:0] exp_q [$];
   string       name_q [$];
   int          n_tests;
   int          n_fail;

   hazard_ctrl #(.REG_W(3), .FWD_EN(0), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst(rst),
      .id_valid(id_valid[0]), .id_rs(id_rs[0]), .id_rs_vld(id_rs_vld[0]),
      .id_rt(id_rt[0]), .id_rt_vld(id_rt_vld[0]), .id_wr_reg(id_wr_reg[0]),
      .id_wr_en(id_wr_en[0]), .id_is_load(id_is_load[0]),
      .mem_busy(mem_busy[0]), .flush(flush[0]),
      .stall_id(stall_id[0]), .bubble_ex(bubble_ex[0]), .freeze(freeze[0]),
      .state(state[0]), .stall_cnt(stall_cnt_a), .frz_cnt(frz_cnt_a)
   );

   hazard_ctrl #(.REG_W(3), .FWD_EN(1), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .id_valid(id_valid[1]), .id_rs(id_rs[1]), .id_rs_vld(id_rs_vld[1]),
      .id_rt(id_rt[1]), .id_rt_vld(id_rt_vld[1]), .id_wr_reg(id_wr_reg[1]),
      .id_wr_en(id_wr_en[1]), .id_is_load(id_is_load[1]),
      .mem_busy(mem_busy[1]), .flush(flush[1]),
      .stall_id(stall_id[1]), .bubble_ex(bubble_ex[1]), .freeze(freeze[1]),
      .state(state[1]), .stall_cnt(stall_cnt_b), .frz_cnt(frz_cnt_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         id_valid[k] = 1'b0; id_rs_vld[k] = 1'b0; id_rt_vld[k] = 1'b0;
         id_wr_en[k] = 1'b0; id_is_load[k] = 1'b0; mem_busy[k] = 1'b0;
         flush[k] = 1'b0; id_rs[k] = 3'd0; id_rt[k] = 3'd0; id_wr_reg[k] = 3'd0;
      end
   endtask

   // driver: one decode cycle on dut d; source/dest of -1 means unused
   task automatic step(input int d, input bit v, input int rs, input int rt,
                       input int wr, input bit ld, input bit mb, input bit fl,
                       input bit e_sid, input bit e_bub, input bit e_frz,
                       input int e_st, input int e_sc, input int e_fc,
                       input string nm);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_inputs();
      id_valid[d]   = v;
      id_rs_vld[d]  = (rs >= 0);
      id_rs[d]      = (rs >= 0) ? 3'(rs) : 3'd0;
      id_rt_vld[d]  = (rt >= 0);
      id_rt[d]      = (rt >= 0) ? 3'(rt) : 3'd0;
      id_wr_en[d]   = (wr >= 0);
      id_wr_reg[d]  = (wr >= 0) ? 3'(wr) : 3'd0;
      id_is_load[d] = ld;
      mem_busy[d]   = mb;
      flush[d]      = fl;
      exp_q.push_back({1'(d), e_sid, e_bub, e_frz, 2'(e_st), 16'(e_sc), 16'(e_fc)});
      name_q.push_back(nm);
   endtask

   // asserts rst mid-cycle, leaving inputs as they are
   task automatic chk_rst(input int d, input string nm);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.push_back({1'(d), 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0});
      name_q.push_back(nm);
   endtask

   // scoreboard monitor
   logic [37:0] mon_exp, mon_act;
   string       mon_nm;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_nm  = name_q.pop_front();
         if (mon_exp[37] == 1'b0)
            mon_act = {1'b0, stall_id[0], bubble_ex[0], freeze[0], state[0],
                       stall_cnt_a, frz_cnt_a};
         else
            mon_act = {1'b1, stall_id[1], bubble_ex[1], freeze[1], state[1],
                       14'd0, stall_cnt_b, 14'd0, frz_cnt_b};
         n_tests++;
         if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got sid/bub/frz=%b st=%0d sc=%0d fc=%0d, want sid/bub/frz=%b st=%0d sc=%0d fc=%0d",
                     mon_nm, mon_exp[37], mon_act[36:34], mon_act[33:32],
                     mon_act[31:16], mon_act[15:0], mon_exp[36:34],
                     mon_exp[33:32], mon_exp[31:16], mon_exp[15:0]);
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, want finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      clear_inputs();
      chk_rst(0, "reset_a");
      chk_rst(1, "reset_b");

      // full interlock: dependent ALU pair
      step(0, 1, 1, 2, 3, 0, 0, 0,  0, 0, 0, RUN, 2'd0, 0, "alu_add_r3");
      step(0, 1, 3, 1, 4, 0, 0, 0,  1, 1, 0, RUN, 0, 0, "raw_ex_stall");
      step(0, 1, 3, 1, 4, 0, 0, 0,  1, 1, 0, HAZ, 1, 0, "raw_mem_stall");
      step(0, 1, 3, 1, 4, 0, 0, 0,  0, 0, 0, HAZ, 2, 0, "raw_released");
      step(0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 2, 0, "idle_after_raw");
      // hazard together with flush
      step(0, 1, 1, 1, 5, 0, 0, 0,  0, 0, 0, RUN, 2, 0, "alu_add_r5");
      step(0, 1, 5, 0, 6, 0, 0, 1,  0, 1, 0, RUN, 2, 0, "flush_over_hazard");
      step(0, 1, 6, 6, 7, 0, 0, 0,  0, 0, 0, RUN, 2, 0, "killed_dest_no_match");
      step(0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 2, 0, "idle_1");
      step(0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 2, 0, "idle_2");
      step(0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 2, 0, "idle_3");
      // memory freeze during a pending hazard
      step(0, 1, 1, 1, 2, 0, 0, 0,  0, 0, 0, RUN, 2, 0, "alu_add_r2");
      step(0, 1, 2, 0, 3, 0, 0, 0,  1, 1, 0, RUN, 2, 0, "raw_before_freeze");
      step(0, 1, 2, 0, 3, 0, 1, 0,  1, 0, 1, HAZ, 3, 0, "freeze_1");
      step(0, 1, 2, 0, 3, 0, 1, 1,  1, 0, 1, FRZ, 3, 1, "freeze_2_flush_ignored");
      step(0, 1, 2, 0, 3, 0, 1, 0,  1, 0, 1, FRZ, 3, 2, "freeze_3");
      step(0, 1, 2, 0, 3, 0, 0, 0,  1, 1, 0, FRZ, 3, 3, "hazard_resumes");
      step(0, 1, 2, 0, 3, 0, 0, 0,  0, 0, 0, HAZ, 4, 3, "hazard_clears");
      step(0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 4, 3, "idle_4");
      // WB-stage dependence does not stall
      step(0, 1, 1, 1, 6, 0, 0, 0,  0, 0, 0, RUN, 4, 3, "wr_r6");
      step(0, 1, 1, 2, 7, 0, 0, 0,  0, 0, 0, RUN, 4, 3, "indep_1");
      step(0, 1, 1, 2, 5, 0, 0, 0,  0, 0, 0, RUN, 4, 3, "indep_2");
      step(0, 1, 6, 6, 4, 0, 0, 0,  0, 0, 0, RUN, 4, 3, "wb_dep_no_stall_a");
      step(0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 4, 3, "idle_5");

      // forwarding build: load-use and ALU->ALU
      step(1, 1, 1, -1, 2, 1, 0, 0, 0, 0, 0, RUN, 0, 0, "ld_r2");
      step(1, 1, 2, 2, 5, 0, 0, 0,  1, 1, 0, RUN, 0, 0, "load_use_stall");
      step(1, 1, 2, 2, 5, 0, 0, 0,  0, 0, 0, HAZ, 1, 0, "load_use_release");
      step(1, 1, 5, 1, 6, 0, 0, 0,  0, 0, 0, RUN, 1, 0, "alu_alu_no_stall");
      step(1, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 1, 0, "idle_b1");
      // WB-stage load dependence
      step(1, 1, 1, -1, 3, 1, 0, 0, 0, 0, 0, RUN, 1, 0, "ld_r3");
      step(1, 1, 2, -1, 1, 0, 0, 0, 0, 0, 0, RUN, 1, 0, "indep_b1");
      step(1, 1, 1, 2, 4, 0, 0, 0,  0, 0, 0, RUN, 1, 0, "indep_b2");
      step(1, 1, 3, 3, 7, 0, 0, 0,  0, 0, 0, RUN, 1, 0, "wb_dep_no_stall_b");
      step(1, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, RUN, 1, 0, "idle_b2");
      // stall counter saturation at 3
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, -1, 2, 1, 0, 0, 0, 0, 0, RUN, 1 + i, 0, "sat_ld");
         step(1, 1, 2, -1, 5, 0, 0, 0, 1, 1, 0, RUN, 1 + i, 0, "sat_stall");
         step(1, 1, 2, -1, 5, 0, 0, 0, 0, 0, 0, HAZ, (i < 2) ? 2 + i : 3, 0, "sat_release");
      end
      // freeze counter saturation at 3
      step(1, 0, -1, -1, -1, 0, 1, 0, 1, 0, 1, RUN, 3, 0, "frz_sat_0");
      step(1, 0, -1, -1, -1, 0, 1, 0, 1, 0, 1, FRZ, 3, 1, "frz_sat_1");
      step(1, 0, -1, -1, -1, 0, 1, 0, 1, 0, 1, FRZ, 3, 2, "frz_sat_2");
      step(1, 0, -1, -1, -1, 0, 1, 0, 1, 0, 1, FRZ, 3, 3, "frz_sat_3");
      step(1, 0, -1, -1, -1, 0, 1, 0, 1, 0, 1, FRZ, 3, 3, "frz_sat_hold");
      step(1, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, FRZ, 3, 3, "frz_exit");
      // reset in the middle of a hazard
      step(1, 1, 1, -1, 2, 1, 0, 0, 0, 0, 0, RUN, 3, 3, "pre_rst_ld");
      step(1, 1, 2, -1, 5, 0, 0, 0, 1, 1, 0, RUN, 3, 3, "pre_rst_stall");
      chk_rst(1, "rst_mid_haz");
      step(1, 1, 2, -1, 5, 0, 0, 0, 0, 0, 0, RUN, 0, 0, "post_rst_no_stall");

      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
